// File: rtl/pid_filter.sv
// Velocity-form PID stage with one shared multiplier.
// Each accepted sample produces one control word five edges later:
//   e0 = setpoint - data_in
//   u  = sat(u + ((k1*e0 + k2*e1 + k3*e2) >>> SHIFT))
// with k1 = p+i+d, k2 = -(p+2d), k3 = d.
//
// Handshake: data_valid_in is a one-cycle strobe that is only accepted
// in ST_IDLE (anything else is dropped). data_valid_out is high for the
// single ST_SEND cycle and qualifies data_out; there is no backpressure.
module pid_filter #(
    parameter int W_DATA = 18,
    parameter int W_COEF = 16,
    parameter int W_OUT  = 18,
    parameter int SHIFT  = 0
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic signed [W_DATA-1:0] data_in,
    input  logic                     data_valid_in,
    input  logic signed [W_DATA-1:0] setpoint_in,
    input  logic signed [W_COEF-1:0] p_coef_in,
    input  logic signed [W_COEF-1:0] i_coef_in,
    input  logic signed [W_COEF-1:0] d_coef_in,
    input  logic                     lock_en_in,
    input  logic                     clear_in,
    input  logic                     update_en_in,
    input  logic                     update_in,
    output logic signed [W_OUT-1:0]  data_out,
    output logic                     data_valid_out,
    output logic                     railed_out,
    output logic [2:0]               state_out
);

    localparam int W_ERR  = W_DATA + 1;
    localparam int W_K    = W_COEF + 2;
    localparam int W_PROD = W_DATA + W_COEF + 3;
    localparam int W_SUM  = W_PROD + 2;
    localparam int W_ACC  = W_SUM + 1;

    localparam logic signed [W_ACC-1:0] U_MAX =
        {{(W_ACC-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_ACC-1:0] U_MIN =
        {{(W_ACC-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_MULT = 3'd2,
        ST_SUM  = 3'd3,
        ST_SEND = 3'd4
    } state_t;

    state_t state, state_next;

    // Shadow and active parameter sets
    logic signed [W_DATA-1:0] sh_setpoint, act_setpoint;
    logic signed [W_COEF-1:0] sh_p, sh_i, sh_d;
    logic                     pending;
    logic signed [W_K-1:0]    k1, k2, k3;
    logic signed [W_K-1:0]    k1_new, k2_new, k3_new;

    // Error history, accumulator, output state
    logic signed [W_ERR-1:0]  e0, e1, e2;
    logic signed [W_SUM-1:0]  sum;
    logic [1:0]               mcnt;
    logic signed [W_OUT-1:0]  u;
    logic                     railed;

    // Shared multiplier operands and clamp datapath
    logic signed [W_K-1:0]    mul_k;
    logic signed [W_ERR-1:0]  mul_e;
    logic signed [W_PROD-1:0] prod;
    logic signed [W_SUM-1:0]  delta;
    logic signed [W_ACC-1:0]  acc;
    logic                     halt;

    assign halt           = clear_in | ~lock_en_in;
    assign data_out       = u;
    assign railed_out     = railed;
    assign data_valid_out = (state == ST_SEND) && !halt;
    assign state_out      = state;

    // Coefficient sums formed from the shadow set at commit time
    always_comb begin
        k1_new = {{2{sh_p[W_COEF-1]}}, sh_p} + {{2{sh_i[W_COEF-1]}}, sh_i}
               + {{2{sh_d[W_COEF-1]}}, sh_d};
        k2_new = -({{2{sh_p[W_COEF-1]}}, sh_p} + {sh_d[W_COEF-1], sh_d, 1'b0});
        k3_new = {{2{sh_d[W_COEF-1]}}, sh_d};
    end

    // Multiplier operand select: one coefficient/error pair per MULT cycle
    always_comb begin
        mul_k = k3;
        mul_e = e2;
        if (mcnt == 2'd0) begin
            mul_k = k1;
            mul_e = e0;
        end else if (mcnt == 2'd1) begin
            mul_k = k2;
            mul_e = e1;
        end
        // Low W_PROD bits of the sign-extended product equal the signed product
        prod = {{(W_PROD-W_K){mul_k[W_K-1]}}, mul_k}
             * {{(W_PROD-W_ERR){mul_e[W_ERR-1]}}, mul_e};
    end

    // Scale the summed products and add to the stored accumulator
    always_comb begin
        delta = sum >>> SHIFT;
        acc   = {{(W_ACC-W_OUT){u[W_OUT-1]}}, u} + {delta[W_SUM-1], delta};
    end

    // State register
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) state <= ST_IDLE;
        else           state <= state_next;
    end

    // Next-state logic; clear or loop disable forces IDLE from any state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (data_valid_in) state_next = ST_ERR;
            ST_ERR:  state_next = ST_MULT;
            ST_MULT: if (mcnt == 2'd2) state_next = ST_SUM;
            ST_SUM:  state_next = ST_SEND;
            ST_SEND: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (halt) state_next = ST_IDLE;
    end

    // Parameter capture and commit; commit waits for IDLE so an in-flight result keeps old values
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            sh_setpoint  <= '0;
            sh_p         <= '0;
            sh_i         <= '0;
            sh_d         <= '0;
            act_setpoint <= '0;
            k1           <= '0;
            k2           <= '0;
            k3           <= '0;
            pending      <= 1'b0;
        end else begin
            if (state == ST_IDLE && pending) begin
                act_setpoint <= sh_setpoint;
                k1           <= k1_new;
                k2           <= k2_new;
                k3           <= k3_new;
                pending      <= 1'b0;
            end
            if (update_in && update_en_in) begin
                sh_setpoint <= setpoint_in;
                sh_p        <= p_coef_in;
                sh_i        <= i_coef_in;
                sh_d        <= d_coef_in;
                pending     <= 1'b1;
            end
        end
    end

    // Datapath: error history, product accumulation, saturating update of u
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            e0     <= '0;
            e1     <= '0;
            e2     <= '0;
            sum    <= '0;
            mcnt   <= '0;
            u      <= '0;
            railed <= 1'b0;
        end else if (halt) begin
            e0     <= '0;
            e1     <= '0;
            e2     <= '0;
            sum    <= '0;
            mcnt   <= '0;
            u      <= '0;
            railed <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_valid_in) begin
                        e0 <= {act_setpoint[W_DATA-1], act_setpoint}
                            - {data_in[W_DATA-1], data_in};
                        e1 <= e0;
                        e2 <= e1;
                    end
                end
                ST_ERR: begin
                    sum  <= '0;
                    mcnt <= '0;
                end
                ST_MULT: begin
                    sum  <= sum + {{2{prod[W_PROD-1]}}, prod};
                    mcnt <= mcnt + 2'd1;
                end
                ST_SUM: begin
                    if (acc > U_MAX) begin
                        u      <= U_MAX[W_OUT-1:0];
                        railed <= 1'b1;
                    end else if (acc < U_MIN) begin
                        u      <= U_MIN[W_OUT-1:0];
                        railed <= 1'b1;
                    end else begin
                        u      <= acc[W_OUT-1:0];
                        railed <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
